des_iter_core: RTL and testbench

Iterative DES engine built on a parametrised round datapath, with R rounds unrolled per clock.
- Performs the full 16-round DES encrypt or decrypt of one 64-bit block per transaction: IP, key schedule (PC-1/PC-2 with rotations), rounds, 32-bit swap, FP.
- Valid/ready handshakes on both input and output.
- Sits between the block-cipher mode controller upstream and the output buffer downstream.
- Successor to the single combinational round: adds sequencing, key schedule, direction mode and flow control.

---
 rtl/des_pkg.sv | 149 ++++++++++++++
 rtl/des_iter_core_round.sv | 18 +
 rtl/des_iter_core.sv | 164 ++++++++++++++++
 tb/tb_des_iter_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES constants, block/key typedefs, core FSM states and the bit-level helper functions.
// Bit numbering follows FIPS-46: vectors are declared [1:N] so x[n] is DES bit n.
package des_pkg;

    typedef logic [1:64] block_t;
    typedef logic [1:56] key56_t;
    typedef logic [1:48] subkey_t;
    typedef logic [1:32] half_t;
    typedef logic [1:28] half28_t;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam int IpTab [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FpTab [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int ETab [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int PTab [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int Pc2Tab [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Eight S-boxes, 64 entries each, laid out row-major (row*16 + column).
    localparam int SboxTab [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // Shifts[k] is the left rotation applied before round k+1.
    localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic block_t ip_perm(block_t x);
        block_t y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IpTab[i]];
        return y;
    endfunction

    function automatic block_t fp_perm(block_t x);
        block_t y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FpTab[i]];
        return y;
    endfunction

    function automatic key56_t pc1_perm(block_t x);
        key56_t y;
        for (int i = 0; i < 56; i++) y[i+1] = x[Pc1Tab[i]];
        return y;
    endfunction

    function automatic subkey_t pc2_perm(key56_t x);
        subkey_t y;
        for (int i = 0; i < 48; i++) y[i+1] = x[Pc2Tab[i]];
        return y;
    endfunction

    function automatic subkey_t e_expand(half_t x);
        subkey_t y;
        for (int i = 0; i < 48; i++) y[i+1] = x[ETab[i]];
        return y;
    endfunction

    function automatic half_t p_perm(half_t x);
        half_t y;
        for (int i = 0; i < 32; i++) y[i+1] = x[PTab[i]];
        return y;
    endfunction

    // Row is formed from the outer bits of each 6-bit group, column from the inner four.
    function automatic half_t s_layer(subkey_t x);
        half_t      y;
        logic [5:0] six;
        int         idx;
        for (int b = 0; b < 8; b++) begin
            six = x[6*b+1 +: 6];
            idx = 64 * b + int'({six[5], six[0], six[4:1]});
            y[4*b+1 +: 4] = 4'(SboxTab[idx]);
        end
        return y;
    endfunction

    // Rotation for 0-based round idx. Decrypt walks the schedule backwards, starting from C0/D0.
    function automatic logic [1:0] rot_amt(int idx, logic dec);
        if (idx < 0 || idx > 15) return 2'd0;
        if (!dec) return 2'(Shifts[idx]);
        if (idx == 0) return 2'd0;
        return 2'(Shifts[16 - idx]);
    endfunction

    function automatic half28_t rot28(half28_t x, logic [1:0] amt, logic right);
        case (amt)
            2'd1:    return right ? {x[28], x[1:27]} : {x[2:28], x[1]};
            2'd2:    return right ? {x[27:28], x[1:26]} : {x[3:28], x[1:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_iter_core_round.sv
// One combinational DES Feistel round: {L, R} -> {R, L ^ P(S(E(R) ^ K))}.
module des_round
    import des_pkg::*;
(
    input  logic [1:32] l_i,
    input  logic [1:32] r_i,
    input  logic [1:48] subkey_i,
    output logic [1:32] l_o,
    output logic [1:32] r_o
);

    // Feistel function and half swap
    always_comb begin
        l_o = r_i;
        r_o = l_i ^ p_perm(s_layer(e_expand(r_i) ^ subkey_i));
    end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core, ROUNDS_PER_CYCLE rounds per clock, valid/ready on both sides.
// Optional macro DES_KEY_PARITY_CHECK_EN adds out_key_err (odd-parity check of every key byte).
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_data,
    input  logic [1:64] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_data,
`ifdef DES_KEY_PARITY_CHECK_EN
    output logic        out_key_err,
`endif
    output logic        busy
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : gen_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] RStep = 5'(ROUNDS_PER_CYCLE);

    state_e  state_q, state_d;
    logic [4:0] ctr_q;
    half_t   l_q, r_q;
    half28_t c_q, d_q;
    logic    dec_q;
    logic    out_valid_q;
    block_t  out_data_q;
    logic    run_last;
    block_t  ip_in;
    key56_t  pc1_key;

    // Round chain: index 0 is the register contents, index ROUNDS_PER_CYCLE the next value.
    half_t   l_c [0:ROUNDS_PER_CYCLE];
    half_t   r_c [0:ROUNDS_PER_CYCLE];
    half28_t c_c [0:ROUNDS_PER_CYCLE];
    half28_t d_c [0:ROUNDS_PER_CYCLE];

    assign l_c[0] = l_q;
    assign r_c[0] = r_q;
    assign c_c[0] = c_q;
    assign d_c[0] = d_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : gen_round
        logic [1:0] amt;
        half28_t    c_rot, d_rot;
        subkey_t    subkey;
        assign amt    = rot_amt(int'(ctr_q) + j, dec_q);
        assign c_rot  = rot28(c_c[j], amt, dec_q);
        assign d_rot  = rot28(d_c[j], amt, dec_q);
        assign subkey = pc2_perm({c_rot, d_rot});
        assign c_c[j+1] = c_rot;
        assign d_c[j+1] = d_rot;
        des_round u_round (
            .l_i      (l_c[j]),
            .r_i      (r_c[j]),
            .subkey_i (subkey),
            .l_o      (l_c[j+1]),
            .r_o      (r_c[j+1])
        );
    end

    assign run_last = (ctr_q + RStep) == 5'd16;
    assign ip_in    = ip_perm(in_data);
    assign pc1_key  = pc1_perm(in_key);

`ifdef DES_KEY_PARITY_CHECK_EN
    logic key_err_pend_q, key_err_q, parity_bad;

    // A key byte is bad when its parity is even
    always_comb begin
        parity_bad = 1'b0;
        for (int b = 0; b < 8; b++) parity_bad = parity_bad | ~(^in_key[8*b+1 +: 8]);
    end

    assign out_key_err = key_err_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (run_last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    // Datapath: load on accept, iterate in RUN, hold result until the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
            key_err_pend_q <= 1'b0;
            key_err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: if (in_valid) begin
                    {l_q, r_q} <= ip_in;
                    {c_q, d_q} <= pc1_key;
                    dec_q      <= in_decrypt;
                    ctr_q      <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
                    key_err_pend_q <= parity_bad;
`endif
                end
                StRun: begin
                    l_q   <= l_c[ROUNDS_PER_CYCLE];
                    r_q   <= r_c[ROUNDS_PER_CYCLE];
                    c_q   <= c_c[ROUNDS_PER_CYCLE];
                    d_q   <= d_c[ROUNDS_PER_CYCLE];
                    ctr_q <= ctr_q + RStep;
                    if (run_last) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= fp_perm({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
`ifdef DES_KEY_PARITY_CHECK_EN
                        key_err_q <= key_err_pend_q;
`endif
                    end
                end
                StDone: if (out_ready) begin
                    out_valid_q <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
                    key_err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Self-checking bench for des_iter_core: known-answer table, latency for every legal
// ROUNDS_PER_CYCLE, backpressure and mid-run reset.
module tb_des_iter_core;

    localparam int RPC  = 1;
    localparam int NEXT = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [1:64] in_data, in_key, out_data;
    logic [NEXT-1:0] ext_valid, ext_in_ready, ext_busy;
    logic [1:64] ext_data [NEXT];
`ifdef DES_KEY_PARITY_CHECK_EN
    logic            out_key_err;
    logic [NEXT-1:0] ext_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    des_iter_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef DES_KEY_PARITY_CHECK_EN
        .out_key_err(out_key_err),
`endif
        .busy       (busy)
    );

    // Faster variants share all inputs so every vector also checks their latency
    for (genvar g = 0; g < NEXT; g++) begin : gen_ext
        des_iter_core #(.ROUNDS_PER_CYCLE(2 << g)) u_ext (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (ext_in_ready[g]),
            .in_data    (in_data),
            .in_key     (in_key),
            .in_decrypt (in_decrypt),
            .out_valid  (ext_valid[g]),
            .out_ready  (out_ready),
            .out_data   (ext_data[g]),
`ifdef DES_KEY_PARITY_CHECK_EN
            .out_key_err(ext_err[g]),
`endif
            .busy       (ext_busy[g])
        );
    end

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } sb_t;

    vec_t vecs [6];
    sb_t  sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        int   w = 0;
        sb_t  e;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_drive", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_key     = v.key;
        in_data    = v.data;
        in_decrypt = v.dec;
        e.data = v.exp;
        e.err  = v.err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '1;
        in_key   = '1;
    endtask

    // Called #1 after the accept edge; counts edges to out_valid for every core.
    task automatic await_result();
        int  n = 0;
        int  ext_lat [NEXT];
        sb_t e;
        for (int g = 0; g < NEXT; g++) ext_lat[g] = -1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            for (int g = 0; g < NEXT; g++) if (ext_valid[g] && ext_lat[g] < 0) ext_lat[g] = n;
        end
        check("latency", 64'(n), 64'(16 / RPC));
        e.data = '0;
        e.err  = 1'b0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check("out_data", out_data, e.data);
        for (int g = 0; g < NEXT; g++) begin
            check($sformatf("ext%0d_latency", g), 64'(ext_lat[g]), 64'(8 >> g));
            check($sformatf("ext%0d_data", g), ext_data[g], e.data);
        end
`ifdef DES_KEY_PARITY_CHECK_EN
        check("key_err", 64'(out_key_err), 64'(e.err));
        for (int g = 0; g < NEXT; g++) check($sformatf("ext%0d_key_err", g), 64'(ext_err[g]), 64'(e.err));
`endif
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out_valid", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hs_busy", 64'(busy), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("hs_key_err", 64'(out_key_err), 64'd0);
`endif
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b0};
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 1'b0};
        vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000, 1'b0};
        vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787, 1'b0};
        vecs[4] = '{64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b1};
        vecs[5] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_decrypt = 1'b0;
        in_data    = '0;
        in_key     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        for (int g = 0; g < NEXT; g++) begin
            check($sformatf("ext%0d_rst_busy", g), 64'(ext_busy[g]), 64'd0);
            check($sformatf("ext%0d_rst_in_ready", g), 64'(ext_in_ready[g]), 64'd1);
        end

        // Known-answer table
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            check("busy_after_accept", 64'(busy), 64'd1);
            await_result();
            handshake();
        end

        // Backpressure: result held for 10 cycles, extra in_valid ignored
        drive(vecs[0]);
        await_result();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                in_valid   = 1'b1;
                in_data    = 64'hFFFF0000FFFF0000;
                in_key     = 64'h0E329232EA6D0D73;
                in_decrypt = 1'b1;
            end
            if (k == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, vecs[0].exp);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        handshake();
        expect_quiet("bp_ignored_block", 20);

        // Reset on the 5th edge after accept discards the block
        drive(vecs[2]);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        expect_quiet("mid_rst_no_output", 20);
        drive(vecs[1]);
        await_result();
        handshake();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
